// File: rtl/spiker_adapter_pkg.sv
// Shared types for the spike streamer: FSM state encoding and beat-index sizing.
package spiker_adapter_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SAMPLE  = 3'd1,
        S_CAPTURE = 3'd2,
        S_STREAM  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam int N_REG_DEFAULT = 24;

    // Beat counter must hold 0..n_reg-1; keep at least one bit for n_reg == 1.
    function automatic int beat_idx_w(input int n_reg);
        return (n_reg > 1) ? $clog2(n_reg) : 1;
    endfunction

    localparam int BEAT_W_DEFAULT = beat_idx_w(N_REG_DEFAULT);

endpackage

// File: rtl/spiker_streamer.sv
// Samples one spike vector from the upstream reader and replays it word by word
// to the SNN core for n_steps timesteps over a valid/ready stream.
module spiker_streamer
    import spiker_adapter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int N_REG      = 24,
    parameter int DATA_WIDTH = 768,
    parameter int STEP_W     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_mode_i,
    input  logic                  start_i,
    input  logic [STEP_W-1:0]     n_steps_i,
    output logic                  sample_o,
    input  logic [DATA_WIDTH-1:0] spikes_i,
    output logic [WIDTH-1:0]      beat_data_o,
    output logic                  beat_valid_o,
    input  logic                  beat_ready_i,
    output logic                  beat_last_o,
    output logic [STEP_W-1:0]     step_idx_o,
    output logic                  busy_o,
    output logic                  done_o,
    output state_t                state_o
);

    localparam int BEAT_W = beat_idx_w(N_REG);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_REG - 1);

    // Handshake: a beat transfers on a rising edge where beat_valid_o && beat_ready_i.
    // Once raised, beat_valid_o and beat_data_o hold until that transfer happens.

    state_t                  state;
    logic [DATA_WIDTH-1:0]   buffer;
    logic [BEAT_W-1:0]       beat_idx;
    logic [STEP_W-1:0]       step_idx;
    logic [STEP_W-1:0]       n_steps_eff;
    logic                    valid_q;
    logic                    sample_q;
    logic                    done_q;
    logic                    busy_q;
    logic                    handshake;
    logic                    unused_test_mode;

    assign unused_test_mode = test_mode_i;
    assign handshake        = valid_q & beat_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            buffer      <= '0;
            beat_idx    <= '0;
            step_idx    <= '0;
            n_steps_eff <= '0;
            valid_q     <= 1'b0;
            sample_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state       <= S_SAMPLE;
                        n_steps_eff <= (n_steps_i == '0) ? STEP_W'(1) : n_steps_i;
                        sample_q    <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                S_SAMPLE: begin
                    state    <= S_CAPTURE;
                    sample_q <= 1'b0;
                end
                S_CAPTURE: begin
                    // The reader's registered output is valid one cycle after the sample pulse.
                    buffer   <= spikes_i;
                    beat_idx <= '0;
                    step_idx <= '0;
                    valid_q  <= 1'b1;
                    state    <= S_STREAM;
                end
                S_STREAM: begin
                    if (handshake) begin
                        if (beat_idx == LAST_BEAT) begin
                            beat_idx <= '0;
                            if (step_idx == n_steps_eff - STEP_W'(1)) begin
                                valid_q <= 1'b0;
                                done_q  <= 1'b1;
                                state   <= S_DONE;
                            end else begin
                                step_idx <= step_idx + STEP_W'(1);
                            end
                        end else begin
                            beat_idx <= beat_idx + BEAT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    valid_q  <= 1'b0;
                    sample_q <= 1'b0;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign beat_data_o  = valid_q ? buffer[int'(beat_idx)*WIDTH +: WIDTH] : '0;
    assign beat_last_o  = valid_q && (beat_idx == LAST_BEAT);
    assign beat_valid_o = valid_q;
    assign sample_o     = sample_q;
    assign done_o       = done_q;
    assign busy_o       = busy_q;
    assign step_idx_o   = step_idx;
    assign state_o      = state;

endmodule

// File: doc/spiker_streamer.md
SPIKER_STREAMER -- requirements
Module: spiker_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning bits per register word and per output beat.
REQ-002 SHALL have parameter N_REG, default 24, meaning number of spike words per sample (beats per timestep).
REQ-003 SHALL have parameter DATA_WIDTH, default 768, meaning spike vector width, required equal to N_REG*WIDTH.
REQ-004 SHALL have parameter STEP_W, default 8, meaning width of the timestep count.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk_i  input  1  clock; all state updates on its rising edge.
REQ-007 rst_ni  input  1  synchronous active-low reset.
REQ-008 test_mode_i  input  1  test mode, no functional effect.
REQ-009 start_i  input  1  request one inference run; honoured only in IDLE.
REQ-010 n_steps_i  input  STEP_W  timesteps per run; 0 treated as 1; sampled on the start handshake.
REQ-011 sample_o  output  1  one-cycle pulse to the upstream spike reader's sample input.
REQ-012 spikes_i  input  DATA_WIDTH  registered spike vector from the upstream reader; word i = bits (i+1)*WIDTH-1 : i*WIDTH.
REQ-013 beat_data_o  output  WIDTH  current spike word to the SNN core.
REQ-014 beat_valid_o, beat_ready_i  output/input  1 each  valid/ready handshake to the core.
REQ-015 beat_last_o  output  1  high with the final beat (word N_REG-1) of each timestep.
REQ-016 step_idx_o  output  STEP_W  index of the timestep being streamed.
REQ-017 busy_o  output  1  high in every state except IDLE.
REQ-018 done_o  output  1  one-cycle pulse at end of run.

Function
REQ-019 SHALL implement FSM IDLE -> SAMPLE -> CAPTURE -> STREAM -> DONE -> IDLE.
REQ-020 IDLE: start_i=1 at an edge -> SAMPLE; latch n_steps_eff = max(n_steps_i,1).
REQ-021 SAMPLE: sample_o=1 for exactly this cycle; next state CAPTURE unconditionally.
REQ-022 CAPTURE: internal DATA_WIDTH buffer <= spikes_i at the closing edge; beat_idx, step_idx cleared; next STREAM.
REQ-023 STREAM: beat_valid_o=1; beat_data_o = buffer word beat_idx; beat_last_o = (beat_idx==N_REG-1).
REQ-024 Handshake = beat_valid_o & beat_ready_i; beat_idx advances only on handshake; valid and data held stable while ready=0.
REQ-025 On handshake with beat_idx==N_REG-1: beat_idx -> 0; if step_idx==n_steps_eff-1 go DONE, else step_idx+1 and stay STREAM with no bubble.
REQ-026 DONE: done_o=1 one cycle, beat_valid_o=0; next IDLE.
REQ-027 The buffer SHALL not change outside CAPTURE; the same sample is replayed for every timestep.
REQ-028 start_i outside IDLE SHALL be ignored (not queued); start_i in DONE ignored.
REQ-029 Latency: start at edge k -> sample_o cycle k+1, capture cycle k+2, first valid cycle k+3; with ready held high, done_o in cycle k+3+N_REG*n_steps_eff.
REQ-030 Counters: beat_idx width clog2(N_REG), step_idx width STEP_W; no wrap beyond limits.
REQ-031 beat_valid_o, sample_o, done_o, beat_last_o SHALL be 0 in all states other than those stated.

Reset
REQ-032 rst_ni=0 at an edge -> IDLE, buffer, beat_idx, step_idx, n_steps_eff cleared; all outputs 0 next cycle.
REQ-033 Reset mid-STREAM SHALL abort with no done_o; pending beat dropped.

Structure
REQ-034 FSM state enum and the N_REG-derived beat index width SHALL live in a shared package spiker_adapter_pkg.
REQ-035 No sub-module; FSM, counters, and word mux inline.

Verification
REQ-036 n_steps_i=1, spikes word i = i+1, ready=1, start at k -> sample_o k+1, beats 1..24 in cycles k+3..k+26, last on 24, done_o at k+27.
REQ-037 n_steps_i=3, ready=1 -> 72 beats back-to-back, step_idx_o 0/1/2, beat_last_o on beats 24, 48, 72, single done_o.
REQ-038 n_steps_i=2, ready toggling randomly -> data stable while stalled, 48 handshakes total in order, no gaps/duplicates.
REQ-039 n_steps_i=0 -> behaves as 1 (24 beats); start_i pulsed during STREAM -> ignored, busy_o stays 1, one done_o only.
REQ-040 rst_ni low after beat 10 of step 0 -> all outputs 0 next cycle, IDLE, no done_o; a new start then streams the fresh sample from word 0.
